// File: rtl/log_fpmul_serial.sv
// Byte-serial floating-point multiplier, parametrised in exponent/mantissa width.
// mode 0 approximates the mantissa product with Mitchell's log sum; mode 1 truncates the exact product.
module log_fpmul_serial #(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [2:0] flags
);
    localparam int W    = 1 + EW + MW;
    localparam int NB   = (W + 7) / 8;
    localparam int BW   = NB * 8;
    localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int ESW  = EW + 2;
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EMAX = (1 << EW) - 1;

    // Handshakes: a byte moves on any rising edge where valid and ready are both high.
    typedef enum logic [2:0] {COLLECT, CALC1, CALC2, CALC3, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic            mode_q, mode_d, sout_q, sout_d;
    logic            any_nan_q, any_nan_d, any_inf_q, any_inf_d, any_zero_q, any_zero_d;
    logic [ESW-1:0]  es_q, es_d;
    logic [MW-1:0]   mr_q, mr_d;
    logic [2:0]      flags_q, flags_d;

    logic [EW-1:0]   ea, eb;
    logic [MW-1:0]   ma, mb;
    logic [MW:0]     msum;
    logic [2*MW+1:0] prod;
    logic [ESW-1:0]  es_base;

    assign ea      = a_q[MW +: EW];
    assign eb      = b_q[MW +: EW];
    assign ma      = a_q[MW-1:0];
    assign mb      = b_q[MW-1:0];
    assign msum    = {1'b0, ma} + {1'b0, mb};
    assign prod    = {{(MW+1){1'b0}}, 1'b1, ma} * {{(MW+1){1'b0}}, 1'b1, mb};
    assign es_base = {2'b00, ea} + {2'b00, eb} - ESW'(BIAS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            mode_q     <= 1'b0;
            sout_q     <= 1'b0;
            any_nan_q  <= 1'b0;
            any_inf_q  <= 1'b0;
            any_zero_q <= 1'b0;
            es_q       <= '0;
            mr_q       <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_q      <= res_d;
            mode_q     <= mode_d;
            sout_q     <= sout_d;
            any_nan_q  <= any_nan_d;
            any_inf_q  <= any_inf_d;
            any_zero_q <= any_zero_d;
            es_q       <= es_d;
            mr_q       <= mr_d;
            flags_q    <= flags_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        mode_d     = mode_q;
        sout_d     = sout_q;
        any_nan_d  = any_nan_q;
        any_inf_d  = any_inf_q;
        any_zero_d = any_zero_q;
        es_d       = es_q;
        mr_d       = mr_q;
        flags_d    = flags_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    a_d[{cnt_q, 3'b000} +: 8] = a_byte;
                    b_d[{cnt_q, 3'b000} +: 8] = b_byte;
                    if (cnt_q == '0) mode_d = mode;
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = CALC1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CALC1: begin
                sout_d     = a_q[W-1] ^ b_q[W-1];
                any_zero_d = (ea == '0) || (eb == '0);
                any_inf_d  = ((ea == '1) && (ma == '0)) || ((eb == '1) && (mb == '0));
                any_nan_d  = ((ea == '1) && (ma != '0)) || ((eb == '1) && (mb != '0));
                state_d    = CALC2;
            end
            CALC2: begin
                // A carry out of the mantissa sum/product renormalises by one binade.
                if (!mode_q) begin
                    mr_d = msum[MW-1:0];
                    es_d = es_base + ESW'(msum[MW]);
                end else if (prod[2*MW+1]) begin
                    mr_d = prod[2*MW:MW+1];
                    es_d = es_base + ESW'(1);
                end else begin
                    mr_d = prod[2*MW-1:MW];
                    es_d = es_base;
                end
                state_d = CALC3;
            end
            CALC3: begin
                res_d   = '0;
                flags_d = '0;
                if (any_nan_q || (any_inf_q && any_zero_q)) begin
                    res_d[W-2 -: EW] = '1;
                    res_d[MW-1]      = 1'b1;
                    flags_d          = 3'b100;
                end else if (any_inf_q) begin
                    res_d[W-1]       = sout_q;
                    res_d[W-2 -: EW] = '1;
                end else if (any_zero_q) begin
                    res_d[W-1] = sout_q;
                end else if ($signed(es_q) >= $signed(ESW'(EMAX))) begin
                    res_d[W-1]       = sout_q;
                    res_d[W-2 -: EW] = '1;
                    flags_d          = 3'b010;
                end else if ($signed(es_q) <= $signed(ESW'(0))) begin
                    res_d[W-1] = sout_q;
                    flags_d    = 3'b001;
                end else begin
                    res_d[W-1:0] = {sout_q, es_q[EW-1:0], mr_q};
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == OUT);
    assign out_byte  = out_valid ? res_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign out_last  = out_valid && (cnt_q == CW'(NB - 1));
    assign flags     = out_valid ? flags_q : 3'b000;
endmodule

// File: tb/tb_log_fpmul_serial.sv
// Directed bench for log_fpmul_serial: FP16 vector table, handshake/reset sequences, FP32 build.
module tb_log_fpmul_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, mode, out_valid, out_ready, out_last;
    logic [7:0] a_byte, b_byte, out_byte;
    logic [2:0] flags;
    logic       in_valid_w, in_ready_w, mode_w, out_valid_w, out_ready_w, out_last_w;
    logic [7:0] a_byte_w, b_byte_w, out_byte_w;
    logic [2:0] flags_w;

    int total = 0;
    int bad   = 0;

    log_fpmul_serial #(.EW(5), .MW(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_byte(a_byte), .b_byte(b_byte), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .flags(flags)
    );

    log_fpmul_serial #(.EW(8), .MW(23)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a_byte(a_byte_w), .b_byte(b_byte_w), .mode(mode_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .out_byte(out_byte_w), .out_last(out_last_w), .flags(flags_w)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] exp_res;
        logic [2:0]  exp_fl;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Byte 1 carries the inverted mode, which the block must ignore.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic m, input bit gaps);
        for (int i = 0; i < 2; i++) begin
            bit hs;
            int guard;
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_byte   = a[i*8 +: 8];
            b_byte   = b[i*8 +: 8];
            mode     = (i == 0) ? m : ~m;
            hs       = 1'b0;
            guard    = 0;
            while (!hs && guard < 20) begin
                hs = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) check("in_accept", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv16(input int stall, output logic [15:0] res, output logic [2:0] fl);
        int lat;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3);
        res = '0;
        fl  = '0;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] hold;
            if (i == 0 && stall > 0) begin
                out_ready = 1'b0;
                hold      = out_byte;
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk); #1;
                    check("stall_stable", {out_valid, out_last, out_byte}, {1'b1, 1'b0, hold});
                end
            end
            check("out_valid", out_valid, 1);
            check("out_last", out_last, (i == 1));
            res[i*8 +: 8] = out_byte;
            if (i == 0) fl = flags;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check("in_ready_after", in_ready, 1);
        check("out_valid_after", out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic [2:0]  fl;
        int          guard;
        logic [31:0] a32, b32, exp32;

        vecs[0] = '{16'h3E00, 16'h3E00, 1'b0, 16'h4000, 3'b000};
        vecs[1] = '{16'h3E00, 16'h3E00, 1'b1, 16'h4080, 3'b000};
        vecs[2] = '{16'h4000, 16'hC200, 1'b0, 16'hC600, 3'b000};
        vecs[3] = '{16'h4000, 16'hC200, 1'b1, 16'hC600, 3'b000};
        vecs[4] = '{16'h7800, 16'h7800, 1'b1, 16'h7C00, 3'b010};
        vecs[5] = '{16'h0400, 16'h0400, 1'b0, 16'h0000, 3'b001};
        vecs[6] = '{16'h8000, 16'h3C00, 1'b1, 16'h8000, 3'b000};
        vecs[7] = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 3'b100};

        rst_n = 1'b0;
        in_valid = 1'b0; a_byte = '0; b_byte = '0; mode = 1'b0; out_ready = 1'b0;
        in_valid_w = 1'b0; a_byte_w = '0; b_byte_w = '0; mode_w = 1'b0; out_ready_w = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_out_last", out_last, 0);
        check("rst_flags", flags, 0);
        check("rst_out_valid_w", out_valid_w, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            send16(vecs[i].a, vecs[i].b, vecs[i].m, (i % 2) == 1);
            recv16((i == 2) ? 3 : 0, res, fl);
            check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_flags", i), fl, vecs[i].exp_fl);
        end

        // Reset while in CALC2.
        send16(16'h3E00, 16'h3E00, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_calc2_out_valid", out_valid, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_calc2_no_result", out_valid, 0);

        // Reset in OUT with byte 0 pending.
        send16(16'h3E00, 16'h3E00, 1'b1, 1'b0);
        guard = 0;
        while (!out_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_out_reached", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_out_out_valid", out_valid, 0);
        check("rst_out_out_byte", out_byte, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send16(16'h3C00, 16'h3C00, 1'b0, 1'b0);
        recv16(0, res, fl);
        check("post_rst_res", res, 16'h3C00);
        check("post_rst_flags", fl, 0);

        // FP32 build: 1.5 * 2.0 exact.
        a32 = 32'h3FC00000;
        b32 = 32'h40000000;
        exp32 = 32'h40400000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w_in_ready%0d", i), in_ready_w, 1);
            in_valid_w = 1'b1;
            a_byte_w   = a32[i*8 +: 8];
            b_byte_w   = b32[i*8 +: 8];
            mode_w     = (i == 0);
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0;
        guard = 0;
        while (!out_valid_w && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("w_latency", guard, 3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w_byte%0d", i), {out_valid_w, out_byte_w}, {1'b1, exp32[i*8 +: 8]});
            check($sformatf("w_last%0d", i), out_last_w, (i == 3));
            check($sformatf("w_flags%0d", i), flags_w, 0);
            out_ready_w = 1'b1;
            @(posedge clk); #1;
            out_ready_w = 1'b0;
        end
        check("w_in_ready_after", in_ready_w, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/log_fpmul_serial.md
# log_fpmul_serial

Parametrised byte-serial floating-point multiplier with a selectable Mitchell logarithmic approximation or truncated exact mantissa product. It generalises the team's fixed FP16 log multiplier to any exponent and mantissa width. It adds valid/ready handshakes on both sides, IEEE-style special-value handling and status flags. It sits behind the chip's 8-bit I/O pins: operands stream in LSB byte first, and the result streams out the same way.

## Interface
- `EW`, 5: exponent width, 3..8; bias = 2^(EW-1)-1.
- `MW`, 10: stored mantissa width, 2..23.
- Derived quantities:
  - W = 1+EW+MW.
  - NB = ceil(W/8), the bytes per operand.
  - Pad bits of the top byte are ignored on input and driven 0 on output.
- Ports:
  - `clk`  in  1  clock; all logic on the rising edge.
  - `rst_n`  in  1  reset, synchronous, active-low.
  - `in_valid`  in  1  `a_byte`/`b_byte` valid.
  - `in_ready`  out  1  block accepts an input byte pair this cycle.
  - `a_byte`  in  8  operand A byte.
  - `b_byte`  in  8  operand B byte.
  - `mode`  in  1  0 = Mitchell log approximation, 1 = exact truncated product; sampled with byte 0.
  - `out_valid`  out  1  `out_byte` valid.
  - `out_ready`  in  1  consumer accepts `out_byte`.
  - `out_byte`  out  8  result byte, LSB byte first.
  - `out_last`  out  1  marks byte NB-1.
  - `flags`  out  3  {nan, ovf, unf}; valid while `out_valid`=1.

## Operation
- State machine states: COLLECT, CALC1, CALC2, CALC3, OUT.
- **COLLECT**:
  - `in_ready`=1.
  - Each handshake (`in_valid` & `in_ready`) writes byte index `cnt` of A and B, then increments `cnt`.
  - The handshake with `cnt`=NB-1 clears `cnt` and goes to CALC1.
  - Cycles with `in_valid`=0 leave `cnt` unchanged; there is no timeout.
- **CALC1**:
  - Unpack S, E, M for both operands.
  - Sout = Sa^Sb.
  - Classify each operand:
    - zero: E=0 (subnormals flush to zero).
    - inf: E=all-ones and M=0.
    - nan: E=all-ones and M≠0.
- **CALC2**, signed exponent sum Es = Ea+Eb-bias, EW+2 bits wide, plus mantissa:
  - mode 0:
    - T = Ma+Mb, MW+1 bits.
    - If T[MW]=1: Mr = T[MW-1:0], Es+1.
    - Otherwise: Mr = T.
  - mode 1:
    - P = {1,Ma}*{1,Mb}, 2MW+2 bits.
    - If P[2MW+1]=1: Mr = P[2MW:MW+1], Es+1.
    - Otherwise: Mr = P[2MW-1:MW].
    - Truncate; no rounding.
- **CALC3**, pack by priority:
  1. Any nan operand, or inf×zero: result {0, all-ones, 1, 0…}, nan=1.
  2. Any inf operand: result {Sout, all-ones, 0}.
  3. Any zero operand: result {Sout, 0, 0}.
  4. Es ≥ 2^EW-1: result {Sout, all-ones, 0}, ovf=1.
  5. Es ≤ 0: result {Sout, 0, 0}, unf=1.
  6. Otherwise: result {Sout, Es[EW-1:0], Mr}.
- **OUT**:
  - `out_valid`=1; `out_byte` = result byte `cnt`.
  - `out_last` = (`cnt`=NB-1).
  - Each handshake increments `cnt`.
  - The handshake on the last byte clears `cnt` and returns to COLLECT.
  - While `out_ready`=0, `out_byte`, `out_last` and `flags` hold stable.
- `in_ready`=0 in every state except COLLECT; there is no overlap of operations.

## Timing
- Reset: state COLLECT, `cnt`=0, A=B=result=0.
- Output values during and after reset: `in_ready`=1 from the first cycle after reset deasserts; `out_valid`=0, `out_byte`=0, `out_last`=0, `flags`=0.
- `rst_n` low in any state aborts the operation within one cycle. No partial result is ever emitted.
- Latency: `out_valid` rises in the 4th cycle after the edge that accepted the last input byte (CALC1, CALC2, CALC3, then OUT).
- Throughput with no stalls: NB input cycles + 3 + NB output cycles.
- `in_ready` rises in the cycle after the final output handshake.
- All outputs are registered or decoded from registered state only; none depends combinationally on `in_valid` or `out_ready`.
- `mode` is captured on the byte-0 handshake only. Changes in `mode` mid-operation are ignored.

## Test plan
All cases use EW=5, MW=10, NB=2; bytes are streamed LSB first.
- Mitchell carry case: A=B=0x3E00 (1.5), mode 0 -> result 0x4000; bytes 0x00 then 0x40; flags 000. Same operands with mode 1 -> 0x4080 (2.25).
- Exact in both modes: A=0x4000, B=0xC200 -> 0xC600 (-6.0) with mode 0 and with mode 1.
- Special values:
  - A=0x7800, B=0x7800 -> 0x7C00, ovf=1.
  - A=0x0400, B=0x0400 -> 0x0000, unf=1.
  - A=0x8000, B=0x3C00 -> 0x8000.
  - A=0x7C00, B=0x0000 -> 0x7E00, nan=1.
- Handshake and latency:
  - Insert `in_valid`=0 gaps between bytes.
  - Hold `out_ready`=0 for 3 cycles on byte 0.
  - Check that `out_byte` stays stable and that `out_valid` rises exactly 4 cycles after the last input acceptance.
  - Check that a new operation is accepted right after `out_last`.
- Reset mid-operation: assert `rst_n`=0 in CALC2 and again in OUT with byte 0 pending.
  - `out_valid` must be 0 the next cycle.
  - A following 0x3C00×0x3C00 operation must return 0x3C00.
- Parametrised build: EW=8, MW=23, NB=4. A=0x3FC00000 (1.5), B=0x40000000 (2.0), mode 1 -> 0x40400000 (3.0). Bytes 0x00, 0x00, 0x40, 0x40, with `out_last` on the 4th byte.
